// File: rtl/sudoku_vga_pkg.sv
// sudoku_vga_pkg: board geometry, colours and renderer FSM states
package sudoku_vga_pkg;
  localparam int H_RES   = 640;
  localparam int V_RES   = 480;
  localparam int CELL    = 48;
  localparam int BORDER  = 2;
  localparam int X0      = 104;
  localparam int Y0      = 24;
  localparam int GLYPH_X = 16;
  localparam int GLYPH_Y = 8;
  localparam int GLYPH_W = 16;
  localparam int GLYPH_H = 32;
  localparam logic [11:0] SCREEN_BG = 12'hFFF;
  localparam logic [11:0] GRID_C    = 12'h000;
  localparam logic [11:0] CELL_BG   = 12'hFFF;
  localparam logic [11:0] SEL_BG    = 12'hFF8;
  localparam logic [11:0] FIXED_FG  = 12'h000;
  localparam logic [11:0] USER_FG   = 12'h00F;
  typedef enum logic [2:0] {CLEAR, IDLE, SETUP, DRAW, DRAIN} state_t;
  function automatic logic [18:0] cell_base(input logic [3:0] row, input logic [3:0] col);
    return 19'((Y0 + int'(row) * CELL) * H_RES + X0 + int'(col) * CELL);
  endfunction
endpackage

// File: rtl/sudoku_cell_scan.sv
// sudoku_cell_scan: raster x/y counters with an incrementally stepped framebuffer address
module sudoku_cell_scan
  import sudoku_vga_pkg::*;
(
  input  logic        CLK_25MH,
  input  logic        RST_n,
  input  logic        i_start,
  input  logic [18:0] i_base,
  input  logic [9:0]  i_w_last,
  input  logic [8:0]  i_h_last,
  output logic        o_active,
  output logic        o_last,
  output logic [9:0]  o_x,
  output logic [8:0]  o_y,
  output logic [18:0] o_addr
);
  logic        r_active;
  logic [9:0]  r_x, r_w;
  logic [8:0]  r_y, r_h;
  logic [18:0] r_addr;
  logic        w_eol;
  assign w_eol    = r_x == r_w;
  assign o_last   = r_active && w_eol && r_y == r_h;
  assign o_active = r_active;
  assign o_x      = r_x;
  assign o_y      = r_y;
  assign o_addr   = r_addr;
  // the final pixel does not advance the address, so it never steps past the scan area
  always_ff @(posedge CLK_25MH) begin
    if (!RST_n) begin
      r_active <= 1'b0;
      r_x      <= '0;
      r_y      <= '0;
      r_w      <= '0;
      r_h      <= '0;
      r_addr   <= '0;
    end else if (i_start) begin
      r_active <= 1'b1;
      r_x      <= '0;
      r_y      <= '0;
      r_w      <= i_w_last;
      r_h      <= i_h_last;
      r_addr   <= i_base;
    end else if (o_last) begin
      r_active <= 1'b0;
    end else if (r_active) begin
      r_x    <= w_eol ? '0 : r_x + 10'd1;
      r_y    <= w_eol ? r_y + 9'd1 : r_y;
      r_addr <= r_addr + (w_eol ? 19'(H_RES) - {9'd0, r_w} : 19'd1);
    end
  end
endmodule

// File: rtl/sudoku_cell_renderer.sv
// sudoku_cell_renderer: framebuffer writer that clears the screen and redraws single Sudoku cells
module sudoku_cell_renderer
  import sudoku_vga_pkg::*;
#(
  parameter int CLR_LINES = V_RES
) (
  input  logic        CLK_25MH,
  input  logic        RST_n,
  input  logic        clear_req,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [3:0]  req_row,
  input  logic [3:0]  req_col,
  input  logic [3:0]  req_digit,
  input  logic        req_fixed,
  input  logic        req_sel,
  output logic [8:0]  glyph_addr,
  input  logic [15:0] glyph_data,
  output logic        fb_we,
  output logic [18:0] fb_addr,
  output logic [11:0] fb_data,
  output logic        busy
);
  state_t      r_state, w_next;
  logic [3:0]  r_row, r_col, r_digit;
  logic        r_fixed, r_sel;
  logic        r_we, r_cand;
  logic [18:0] r_addr;
  logic [11:0] r_colour;
  logic [3:0]  r_bit;
  logic        w_start, w_active, w_last, w_oor, w_border, w_grow, w_glyph;
  logic [9:0]  w_x;
  logic [8:0]  w_y;
  logic [18:0] w_addr;
  assign w_oor = r_row > 4'd8 || r_col > 4'd8;
  always_comb begin
    w_next  = r_state;
    w_start = 1'b0;
    case (r_state)
      CLEAR: begin
        w_start = !w_active;
        w_next  = w_last ? DRAIN : CLEAR;
      end
      IDLE:  w_next = clear_req ? CLEAR : req_valid ? SETUP : IDLE;
      SETUP: begin
        w_start = !w_oor;
        w_next  = w_oor ? IDLE : DRAW;
      end
      DRAW:  w_next = w_last ? DRAIN : DRAW;
      DRAIN: w_next = IDLE;
      default: w_next = CLEAR;
    endcase
  end
  sudoku_cell_scan u_scan (
    .CLK_25MH (CLK_25MH),
    .RST_n    (RST_n),
    .i_start  (w_start),
    .i_base   (r_state == CLEAR ? 19'd0 : cell_base(r_row, r_col)),
    .i_w_last (r_state == CLEAR ? 10'(H_RES - 1) : 10'(CELL - 1)),
    .i_h_last (r_state == CLEAR ? 9'(CLR_LINES - 1) : 9'(CELL - 1)),
    .o_active (w_active),
    .o_last   (w_last),
    .o_x      (w_x),
    .o_y      (w_y),
    .o_addr   (w_addr)
  );
  assign w_border = w_x < 10'(BORDER) || w_y < 9'(BORDER) ||
                    w_x >= 10'(CELL - BORDER) || w_y >= 9'(CELL - BORDER);
  assign w_grow   = w_y >= 9'(GLYPH_Y) && w_y < 9'(GLYPH_Y + GLYPH_H);
  assign w_glyph  = r_state == DRAW && !w_border && w_grow && r_digit != 4'd0 && r_digit <= 4'd9 &&
                    w_x >= 10'(GLYPH_X) && w_x < 10'(GLYPH_X + GLYPH_W);
  // ROM answers one cycle later, in step with the registered write below
  assign glyph_addr = (r_state == DRAW && w_grow) ? {r_digit, 5'd0} + (w_y - 9'(GLYPH_Y)) : 9'd0;
  always_ff @(posedge CLK_25MH) begin
    if (!RST_n) begin
      r_state  <= CLEAR;
      r_we     <= 1'b0;
      r_addr   <= '0;
      r_colour <= '0;
      r_cand   <= 1'b0;
      r_bit    <= '0;
      r_row    <= '0;
      r_col    <= '0;
      r_digit  <= '0;
      r_fixed  <= 1'b0;
      r_sel    <= 1'b0;
    end else begin
      r_state  <= w_next;
      r_we     <= w_active;
      r_addr   <= w_addr;
      r_colour <= r_state == CLEAR ? SCREEN_BG : w_border ? GRID_C : r_sel ? SEL_BG : CELL_BG;
      r_cand   <= w_glyph;
      r_bit    <= ~w_x[3:0];
      if (req_valid && req_ready) begin
        r_row   <= req_row;
        r_col   <= req_col;
        r_digit <= req_digit;
        r_fixed <= req_fixed;
        r_sel   <= req_sel;
      end
    end
  end
  assign fb_we     = r_we;
  assign fb_addr   = r_addr;
  assign fb_data   = (r_cand && glyph_data[r_bit]) ? (r_fixed ? FIXED_FG : USER_FG) : r_colour;
  assign req_ready = r_state == IDLE && !clear_req;
  assign busy      = r_state != IDLE;
endmodule

// File: tb/tb_sudoku_cell_renderer.sv
// tb_sudoku_cell_renderer: randomized cell draws and screen clears checked against a pixel-rule model
module tb_sudoku_cell_renderer;
  localparam int LINES = 16;
  logic        clk = 1'b0, rst_n = 1'b0, clear_req = 1'b0, req_valid = 1'b0;
  logic        req_fixed = 1'b0, req_sel = 1'b0;
  logic [3:0]  req_row = '0, req_col = '0, req_digit = '0;
  logic        req_ready, fb_we, busy;
  logic [8:0]  glyph_addr;
  logic [15:0] glyph_data = '0;
  logic [18:0] fb_addr;
  logic [11:0] fb_data;
  logic [15:0] rom [512];
  int          obs_d [2304];
  int          obs_a [2304];
  int          g_y8;
  int          n_tests = 0, n_fail = 0;
  always #20 clk = ~clk;
  always @(posedge clk) glyph_data <= rom[glyph_addr];
  sudoku_cell_renderer #(.CLR_LINES(LINES)) dut (
    .CLK_25MH   (clk),
    .RST_n      (rst_n),
    .clear_req  (clear_req),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_row    (req_row),
    .req_col    (req_col),
    .req_digit  (req_digit),
    .req_fixed  (req_fixed),
    .req_sel    (req_sel),
    .glyph_addr (glyph_addr),
    .glyph_data (glyph_data),
    .fb_we      (fb_we),
    .fb_addr    (fb_addr),
    .fb_data    (fb_data),
    .busy       (busy)
  );
  task automatic check(input string tag, input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask
  function automatic int pix(input int x, input int y, input int d, input bit fx, input bit sl);
    logic [15:0] bits;
    if (x < 2 || y < 2 || x >= 46 || y >= 46) return 'h000;
    if (d >= 1 && d <= 9 && x >= 16 && x < 32 && y >= 8 && y < 40) begin
      bits = rom[d * 32 + y - 8];
      if (bits[15 - (x - 16)]) return fx ? 'h000 : 'h00F;
    end
    return sl ? 'hFF8 : 'hFFF;
  endfunction
  task automatic rand_rom();
    for (int i = 0; i < 512; i++) rom[i] = 16'($urandom);
  endtask
  task automatic run_clear(input string tag);
    int nw, bad, last_we, rdy;
    nw = 0; bad = 0; last_we = 0; rdy = 0;
    for (int c = 1; c <= LINES * 640 + 20; c++) begin
      @(negedge clk);
      if (fb_we) begin
        if (int'(fb_addr) != nw || fb_data != 12'hFFF) bad++;
        nw++;
        last_we = c;
      end
      if (req_ready) begin
        rdy = c;
        break;
      end
    end
    check({tag, "_writes"}, nw, LINES * 640);
    check({tag, "_bad_px"}, bad, 0);
    check({tag, "_ready_cyc"}, rdy, last_we + 1);
  endtask
  task automatic do_cell(input string tag, input int row, input int col, input int d,
                         input bit fx, input bit sl, input int abort_at = 0);
    int base, nw, bad, gbad, first_we, last_we, rdy, k, y, gexp, setup_we, exp_a;
    bit oor;
    oor = row > 8 || col > 8;
    base = (24 + row * 48) * 640 + 104 + col * 48;
    nw = 0; bad = 0; gbad = 0; first_we = 0; last_we = 0; rdy = 0; setup_we = -1; g_y8 = -1;
    for (int i = 0; i < 2304; i++) begin
      obs_d[i] = -1;
      obs_a[i] = -1;
    end
    for (int i = 0; i < 10 && !req_ready; i++) @(negedge clk);
    check({tag, "_ready_in"}, int'(req_ready), 1);
    req_row = 4'(row); req_col = 4'(col); req_digit = 4'(d); req_fixed = fx; req_sel = sl;
    req_valid = 1'b1;
    for (int c = 1; c <= 2400; c++) begin
      @(negedge clk);
      req_valid = 1'b0;
      if (c == abort_at) begin
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check({tag, "_rst_we"}, int'(fb_we), 0);
        check({tag, "_rst_addr"}, int'(fb_addr), 0);
        return;
      end
      if (c == 1) setup_we = int'(fb_we);
      if (!oor && c >= 2 && c <= 2305) begin
        k = c - 2;
        y = k / 48;
        gexp = (y >= 8 && y < 40) ? d * 32 + y - 8 : 0;
        if (int'(glyph_addr) != gexp) gbad++;
        if (k == 8 * 48) g_y8 = int'(glyph_addr);
      end
      if (fb_we) begin
        if (first_we == 0) first_we = c;
        last_we = c;
        if (nw < 2304) begin
          exp_a = base + (nw / 48) * 640 + nw % 48;
          if (int'(fb_addr) != exp_a || int'(fb_data) != pix(nw % 48, nw / 48, d, fx, sl)) bad++;
          obs_d[nw] = int'(fb_data);
          obs_a[nw] = int'(fb_addr);
        end
        nw++;
      end
      if (req_ready) begin
        rdy = c;
        break;
      end
    end
    check({tag, "_setup_we"}, setup_we, 0);
    check({tag, "_writes"}, nw, oor ? 0 : 2304);
    check({tag, "_bad_px"}, bad, 0);
    check({tag, "_ready_cyc"}, rdy, oor ? 2 : 2307);
    if (!oor) begin
      check({tag, "_gaddr_bad"}, gbad, 0);
      check({tag, "_first_we"}, first_we, 3);
      check({tag, "_last_we"}, last_we, 2306);
    end
  endtask
  initial begin
    rand_rom();
    repeat (3) @(negedge clk);
    check("rst_we", int'(fb_we), 0);
    check("rst_addr", int'(fb_addr), 0);
    check("rst_data", int'(fb_data), 0);
    check("rst_gaddr", int'(glyph_addr), 0);
    check("rst_ready", int'(req_ready), 0);
    check("rst_busy", int'(busy), 1);
    rst_n = 1'b1;
    run_clear("clr_reset");
    do_cell("c00", 0, 0, 0, 1'b0, 1'b0);
    check("c00_first_addr", obs_a[0], 15464);
    check("c00_first_data", obs_d[0], 'h000);
    check("c00_x2y2_addr", obs_a[2 * 48 + 2], 16746);
    check("c00_x2y2_data", obs_d[2 * 48 + 2], 'hFFF);
    do_cell("c88", 8, 8, 3, 1'b1, 1'b0);
    check("c88_first_addr", obs_a[0], 261608);
    check("c88_last_addr", obs_a[2303], 291735);
    check("c88_first_data", obs_d[0], 'h000);
    check("c88_last_data", obs_d[2303], 'h000);
    for (int i = 0; i < 512; i++) rom[i] = '0;
    rom[160] = 16'h8000;
    do_cell("c44", 4, 4, 5, 1'b0, 1'b1);
    check("c44_gaddr_y8", g_y8, 160);
    check("c44_px16_8", obs_d[8 * 48 + 16], 'h00F);
    check("c44_px17_8", obs_d[8 * 48 + 17], 'hFF8);
    check("c44_px16_9", obs_d[9 * 48 + 16], 'hFF8);
    rand_rom();
    req_row = 4'd3; req_col = 4'd5; req_digit = 4'd7; req_fixed = 1'b1; req_sel = 1'b0;
    clear_req = 1'b1;
    req_valid = 1'b1;
    #1 check("clrq_ready_low", int'(req_ready), 0);
    @(negedge clk);
    clear_req = 1'b0;
    check("clrq_busy", int'(busy), 1);
    run_clear("clr_req");
    do_cell("after_clr", 3, 5, 7, 1'b1, 1'b0);
    for (int t = 0; t < 5; t++) begin
      rand_rom();
      do_cell("rnd", $urandom_range(0, 9), $urandom_range(0, 9), $urandom_range(0, 15),
              1'($urandom), 1'($urandom));
    end
    do_cell("oor", 9, 2, 4, 1'b0, 1'b0);
    do_cell("abort", 2, 6, 1, 1'b0, 1'b0, 1000);
    run_clear("clr_abort");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
